ar_qos_arbiter: RTL and testbench
=================================

Name: ar_qos_arbiter

Overview:
- Read-address-channel arbiter that shares the single AR path (master mux, address decoder, slave ports) among up to Num_Masters requesters.
- Arbitration uses ARQOS priority, round-robin tie-break and starvation aging.
- Tracks outstanding reads per master and masks any master at its limit.
- Drives the master-mux select and the grant/request handshake for the AR channel controller, and consumes its handshake-done and R-last completion events.

Parameters:
- Num_Masters, 4, number of requesting masters (2..8)
- Master_ID_Size, $clog2(Num_Masters), width of master index
- Max_Outstanding, 4, maximum accepted-but-incomplete reads per master (1..15)
- Age_Limit, 15, cycles a blocked eligible request waits before becoming urgent (1..15)

Ports:
- ACLK  in  1  single clock, all logic on rising edge
- ARESET  in  1  reset; one clock; reset is synchronous and active-high
- Req_Valid  in  Num_Masters  per-master ARVALID
- Req_Qos  in  4*Num_Masters  per-master ARQOS, master i at bits [4i+3:4i]
- AR_HandShake_Done  in  1  pulse: granted AR transfer accepted by slave
- Rd_Done_Valid  in  1  pulse: a read burst completed (RLAST handshake)
- Rd_Done_ID  in  Master_ID_Size  master owning the completed burst
- Grant_Valid  out  1  a master is currently granted
- Selected_Master  out  Master_ID_Size  index of granted master; mux select
- Grant_Onehot  out  Num_Masters  one-hot grant, drives ARREADY demux
- Channel_Request  out  1  any eligible request pending while idle
- Outstanding_Full  out  Num_Masters  master i at Max_Outstanding
- Count_Error  out  1  sticky: completion received for master with zero outstanding

Behaviour:
- Reset: all outputs 0, state IDLE, all outstanding counters 0, ages 0, RR pointer 0. A reset asserted mid-grant drops the grant in the next cycle with no completion bookkeeping.
- Eligible[i] = Req_Valid[i] & (Outstanding[i] < Max_Outstanding).
- Channel_Request is combinational: (state==IDLE) & |Eligible.
- FSM IDLE:
  - If any eligible request, choose winner, register Grant_Valid=1, Selected_Master and Grant_Onehot at the next edge, and go to GRANT. Latency is 1 cycle from request to grant.
  - Else stay in IDLE with Grant_Valid=0.
- FSM GRANT:
  - Grant is held unchanged regardless of Req_Valid/Req_Qos changes until AR_HandShake_Done.
  - On AR_HandShake_Done, next edge: Grant_Valid=0, Grant_Onehot=0, Selected_Master retains its value, state goes to IDLE.
  - The granted master's outstanding count increments and the RR pointer moves to winner+1 (mod Num_Masters).
  - Minimum spacing between grants is 2 cycles.
- Winner selection:
  - Effective priority = 16 if Age[i]==Age_Limit (urgent), else Req_Qos[i].
  - Highest effective priority wins.
  - Ties are broken by the first index found scanning upward from the RR pointer, wrapping.
- Aging:
  - Each cycle, Age[i] increments (saturating at Age_Limit) if Eligible[i] and master i is not the current grantee.
  - Age[i] clears on grant to i or when Req_Valid[i]=0.
  - Aging is frozen for masters at outstanding limit.
- Outstanding counters:
  - +1 on AR_HandShake_Done for the grantee.
  - -1 on Rd_Done_Valid for Rd_Done_ID.
  - If both events hit the same master in one cycle, the count is unchanged.
  - A decrement at 0 is ignored and sets Count_Error (cleared only by reset).
  - Outstanding_Full[i] is registered: count==Max_Outstanding.
- Rd_Done_ID >= Num_Masters: ignored and sets Count_Error.
- AR_HandShake_Done in IDLE: ignored and sets Count_Error.

Test Plan:
- Reset, then Req_Valid=0001, Qos0=0 -> Channel_Request=1 same cycle; Grant_Valid=1, Selected_Master=0, Grant_Onehot=0001 one cycle later; hold until AR_HandShake_Done, then Grant_Valid=0 next cycle.
- Req_Valid=1111, Qos={3,9,9,1} (masters 3..0) -> first grant master 1 (RR ptr 0), next grant master 2, then master 1 (ptr 3 wraps to 0, 1 first in scan).
- Master 0 Qos=0 and master 1 Qos=15, both held valid, slave handshakes every grant, Age_Limit=15 -> master 0 becomes urgent and is granted no later than ~16 cycles after its request first went pending (master 0 waiting continuously).
- Max_Outstanding=2, master 2 gets 2 handshakes with no Rd_Done -> Outstanding_Full[2]=1, master 2 never granted. Then Rd_Done_Valid with ID=2 -> full clears and master 2 granted next arbitration.
- Same-cycle AR_HandShake_Done for grantee 3 and Rd_Done for ID 3 at count 1 -> count stays 1. Rd_Done for ID 0 at count 0 -> Count_Error=1 and stays 1.
- ARESET asserted while in GRANT with counts {1,2,0,1} -> next cycle all outputs 0 and counts 0. After release, a fresh request is granted with 1-cycle latency.

Source files
------------

// File: rtl/ar_qos_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ar_qos_arbiter
// Purpose  : AR-channel arbiter with QoS priority, round-robin tie-break,
//            starvation aging and per-master outstanding-read limiting.
// Revision : 1.0  initial release
// ============================================================================
module ar_qos_arbiter #(
    parameter int Num_Masters     = 4,
    parameter int Master_ID_Size  = $clog2(Num_Masters),
    parameter int Max_Outstanding = 4,
    parameter int Age_Limit       = 15
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [Num_Masters-1:0]    Req_Valid,
    input  logic [4*Num_Masters-1:0]  Req_Qos,
    input  logic                      AR_HandShake_Done,
    input  logic                      Rd_Done_Valid,
    input  logic [Master_ID_Size-1:0] Rd_Done_ID,
    output logic                      Grant_Valid,
    output logic [Master_ID_Size-1:0] Selected_Master,
    output logic [Num_Masters-1:0]    Grant_Onehot,
    output logic                      Channel_Request,
    output logic [Num_Masters-1:0]    Outstanding_Full,
    output logic                      Count_Error
);

    localparam logic [3:0] c_MAX_OUT = 4'(Max_Outstanding);
    localparam logic [3:0] c_AGE_LIM = 4'(Age_Limit);
    localparam int         c_ID_SPAN = 1 << Master_ID_Size;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                    state_q;
    logic [Master_ID_Size-1:0] rr_ptr_q;
    logic [Master_ID_Size-1:0] sel_q;
    logic                      grant_valid_q;
    logic [Num_Masters-1:0]    onehot_q;
    logic [Num_Masters-1:0]    full_q;
    logic                      cnt_err_q;
    logic [3:0]                cnt_q [Num_Masters];
    logic [3:0]                age_q [Num_Masters];

    logic [3:0]                cnt_d [Num_Masters];
    logic [3:0]                age_d [Num_Masters];
    logic                      cnt_err_d;

    logic [3:0]                w_qos [Num_Masters];
    logic [Num_Masters-1:0]    w_eligible;
    logic                      w_any_eligible;
    logic [Master_ID_Size-1:0] w_winner;
    logic [c_ID_SPAN-1:0]      w_id_in_range;
    logic                      w_grant_now;
    logic                      w_hs_ok;
    logic                      w_rd_ok;

    generate
        for (genvar i = 0; i < Num_Masters; i++) begin : g_master
            assign w_qos[i]      = Req_Qos[4*i +: 4];
            assign w_eligible[i] = Req_Valid[i] & (cnt_q[i] < c_MAX_OUT);
        end
        // IDs that fit the index width but name no real master
        for (genvar j = 0; j < c_ID_SPAN; j++) begin : g_id_range
            assign w_id_in_range[j] = (j < Num_Masters);
        end
    endgenerate

    assign w_grant_now = (state_q == S_IDLE) && w_any_eligible;
    assign w_hs_ok     = (state_q == S_GRANT) && AR_HandShake_Done;
    assign w_rd_ok     = Rd_Done_Valid && w_id_in_range[Rd_Done_ID];

    // Scan upward from the RR pointer; strict '>' keeps the first index on ties.
    always_comb begin : p_winner
        int                        idx_int;
        logic [Master_ID_Size-1:0] idx;
        logic [4:0]                prio;
        logic [4:0]                best_prio;
        idx_int        = 0;
        idx            = '0;
        prio           = '0;
        best_prio      = '0;
        w_any_eligible = 1'b0;
        w_winner       = '0;
        for (int k = 0; k < Num_Masters; k++) begin
            idx_int = int'(rr_ptr_q) + k;
            if (idx_int >= Num_Masters) begin
                idx_int = idx_int - Num_Masters;
            end
            idx  = Master_ID_Size'(idx_int);
            prio = (age_q[idx] == c_AGE_LIM) ? 5'd16 : {1'b0, w_qos[idx]};
            if (w_eligible[idx] && (!w_any_eligible || (prio > best_prio))) begin
                w_any_eligible = 1'b1;
                best_prio      = prio;
                w_winner       = idx;
            end
        end
    end

    always_comb begin : p_next
        logic inc;
        logic dec;
        inc       = 1'b0;
        dec       = 1'b0;
        cnt_err_d = cnt_err_q;
        if (AR_HandShake_Done && (state_q == S_IDLE)) begin
            cnt_err_d = 1'b1;
        end
        if (Rd_Done_Valid && !w_id_in_range[Rd_Done_ID]) begin
            cnt_err_d = 1'b1;
        end
        for (int i = 0; i < Num_Masters; i++) begin
            inc      = w_hs_ok && (sel_q == Master_ID_Size'(i));
            dec      = w_rd_ok && (Rd_Done_ID == Master_ID_Size'(i));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (dec && !inc) begin
                if (cnt_q[i] == 4'd0) begin
                    cnt_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                end
            end

            // Masters blocked by their outstanding limit keep their age.
            age_d[i] = age_q[i];
            if (!Req_Valid[i]) begin
                age_d[i] = 4'd0;
            end else if (w_grant_now && (w_winner == Master_ID_Size'(i))) begin
                age_d[i] = 4'd0;
            end else if (w_eligible[i]
                         && !((state_q == S_GRANT) && (sel_q == Master_ID_Size'(i)))
                         && (age_q[i] != c_AGE_LIM)) begin
                age_d[i] = age_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            sel_q         <= '0;
            grant_valid_q <= 1'b0;
            onehot_q      <= '0;
            full_q        <= '0;
            cnt_err_q     <= 1'b0;
            for (int i = 0; i < Num_Masters; i++) begin
                cnt_q[i] <= 4'd0;
                age_q[i] <= 4'd0;
            end
        end else begin
            cnt_err_q <= cnt_err_d;
            for (int i = 0; i < Num_Masters; i++) begin
                cnt_q[i]  <= cnt_d[i];
                age_q[i]  <= age_d[i];
                full_q[i] <= (cnt_d[i] == c_MAX_OUT);
            end
            case (state_q)
                S_IDLE: begin
                    if (w_any_eligible) begin
                        state_q       <= S_GRANT;
                        grant_valid_q <= 1'b1;
                        sel_q         <= w_winner;
                        onehot_q      <= Num_Masters'(1) << w_winner;
                    end
                end
                S_GRANT: begin
                    // Selected_Master deliberately keeps the last grantee.
                    if (AR_HandShake_Done) begin
                        state_q       <= S_IDLE;
                        grant_valid_q <= 1'b0;
                        onehot_q      <= '0;
                        rr_ptr_q      <= (sel_q == Master_ID_Size'(Num_Masters - 1))
                                         ? '0 : sel_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign Grant_Valid      = grant_valid_q;
    assign Selected_Master  = sel_q;
    assign Grant_Onehot     = onehot_q;
    assign Channel_Request  = (state_q == S_IDLE) && (|w_eligible);
    assign Outstanding_Full = full_q;
    assign Count_Error      = cnt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ar_qos_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ar_qos_arbiter
// Purpose  : Directed scoreboard bench for ar_qos_arbiter (4 masters, limit 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_ar_qos_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  Req_Valid;
    logic [15:0] Req_Qos;
    logic        AR_HandShake_Done;
    logic        Rd_Done_Valid;
    logic [1:0]  Rd_Done_ID;
    logic        Grant_Valid;
    logic [1:0]  Selected_Master;
    logic [3:0]  Grant_Onehot;
    logic        Channel_Request;
    logic [3:0]  Outstanding_Full;
    logic        Count_Error;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_gv = 1'b0;

    ar_qos_arbiter #(
        .Num_Masters    (4),
        .Max_Outstanding(2),
        .Age_Limit      (15)
    ) dut (
        .ACLK             (ACLK),
        .ARESET           (ARESET),
        .Req_Valid        (Req_Valid),
        .Req_Qos          (Req_Qos),
        .AR_HandShake_Done(AR_HandShake_Done),
        .Rd_Done_Valid    (Rd_Done_Valid),
        .Rd_Done_ID       (Rd_Done_ID),
        .Grant_Valid      (Grant_Valid),
        .Selected_Master  (Selected_Master),
        .Grant_Onehot     (Grant_Onehot),
        .Channel_Request  (Channel_Request),
        .Outstanding_Full (Outstanding_Full),
        .Count_Error      (Count_Error)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every new grant is matched against the next expected grantee.
    always @(negedge ACLK) begin : p_monitor
        int e;
        if (Grant_Valid === 1'b1 && prev_gv !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got master %0d expected none", Selected_Master);
            end else begin
                e = exp_q.pop_front();
                if (Selected_Master !== 2'(e)) begin
                    errors++;
                    $display("FAIL grant_master: got %0d expected %0d", Selected_Master, e);
                end
                checks++;
                if (Grant_Onehot !== (4'b0001 << e)) begin
                    errors++;
                    $display("FAIL grant_onehot: got %b expected %b", Grant_Onehot, 4'b0001 << e);
                end
            end
        end
        prev_gv = Grant_Valid;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (Grant_Valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (Grant_Valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant expected a grant within 40 cycles");
        end
    endtask

    task automatic grant_hs(input logic [3:0] next_req, input logic rd, input logic [1:0] rd_id);
        wait_grant();
        AR_HandShake_Done = 1'b1;
        Rd_Done_Valid     = rd;
        Rd_Done_ID        = rd_id;
        Req_Valid         = next_req;
        tick();
        AR_HandShake_Done = 1'b0;
        Rd_Done_Valid     = 1'b0;
    endtask

    task automatic pulse_rd(input logic [1:0] id);
        Rd_Done_Valid = 1'b1;
        Rd_Done_ID    = id;
        tick();
        Rd_Done_Valid = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; Req_Valid = '0; Req_Qos = '0;
        AR_HandShake_Done = 1'b0; Rd_Done_Valid = 1'b0; Rd_Done_ID = '0;
        tick(); tick();
        ARESET = 1'b0;
        chk("rst_grant_valid", Grant_Valid, 0);
        chk("rst_onehot", Grant_Onehot, 0);
        chk("rst_sel", Selected_Master, 0);
        chk("rst_full", Outstanding_Full, 0);
        chk("rst_err", Count_Error, 0);
        chk("rst_chreq", Channel_Request, 0);

        // Single request: same-cycle Channel_Request, 1-cycle grant, hold.
        Req_Valid = 4'b0001;
        #1;
        chk("chreq_comb", Channel_Request, 1);
        exp_q.push_back(0);
        tick();
        chk("grant_latency", Grant_Valid, 1);
        chk("chreq_in_grant", Channel_Request, 0);
        Req_Valid = 4'b0000; Req_Qos = 16'hFFFF;
        tick(); tick();
        chk("grant_hold", Grant_Valid, 1);
        chk("grant_hold_sel", Selected_Master, 0);
        AR_HandShake_Done = 1'b1;
        tick();
        AR_HandShake_Done = 1'b0;
        chk("hs_drop_valid", Grant_Valid, 0);
        chk("hs_drop_onehot", Grant_Onehot, 0);
        chk("hs_keep_sel", Selected_Master, 0);
        pulse_rd(0);

        // QoS {3,9,9,1}: grants 1, 2, 1.
        Req_Qos = 16'h3991; Req_Valid = 4'b1111;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
        grant_hs(4'b1111, 1'b0, 2'd0);
        grant_hs(4'b1111, 1'b0, 2'd0);
        grant_hs(4'b0000, 1'b0, 2'd0);
        chk("full_m1", Outstanding_Full, 4'b0010);
        pulse_rd(1); pulse_rd(1); pulse_rd(2);
        chk("full_cleared", Outstanding_Full, 0);

        // Aging: master 1 (qos 15) wins 8 times, then master 0 turns urgent.
        Req_Qos = 16'h00F0; Req_Valid = 4'b0011;
        for (int g = 0; g < 8; g++) exp_q.push_back(1);
        exp_q.push_back(0);
        for (int g = 0; g < 8; g++) grant_hs(4'b0011, 1'b1, 2'd1);
        grant_hs(4'b0000, 1'b0, 2'd0);
        chk("no_err_same_cycle_at_zero", Count_Error, 0);
        pulse_rd(0);

        // Outstanding limit on master 2.
        Req_Qos = 16'h0000; Req_Valid = 4'b0100;
        exp_q.push_back(2); exp_q.push_back(2);
        grant_hs(4'b0100, 1'b0, 2'd0);
        grant_hs(4'b0100, 1'b0, 2'd0);
        chk("full_m2", Outstanding_Full, 4'b0100);
        chk("chreq_blocked", Channel_Request, 0);
        tick(); tick(); tick();
        chk("blocked_no_grant", Grant_Valid, 0);
        exp_q.push_back(2);
        pulse_rd(2);
        chk("full_m2_clear", Outstanding_Full, 0);
        chk("chreq_unblocked", Channel_Request, 1);
        grant_hs(4'b0000, 1'b0, 2'd0);
        pulse_rd(2); pulse_rd(2);

        // Same-cycle +1/-1 on grantee 3 at count 1 keeps the count at 1.
        chk("err_before", Count_Error, 0);
        Req_Valid = 4'b1000;
        exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
        grant_hs(4'b1000, 1'b0, 2'd0);
        grant_hs(4'b0000, 1'b1, 2'd3);
        Req_Valid = 4'b1000;
        grant_hs(4'b0000, 1'b0, 2'd0);
        chk("full_m3", Outstanding_Full, 4'b1000);
        pulse_rd(0);
        chk("err_set", Count_Error, 1);
        tick(); tick(); tick();
        chk("err_sticky", Count_Error, 1);

        // Build counts {1,2,0,1}, then reset in the middle of a grant.
        pulse_rd(3);
        Req_Valid = 4'b0100;
        exp_q.push_back(2); exp_q.push_back(2);
        grant_hs(4'b0100, 1'b0, 2'd0);
        grant_hs(4'b0000, 1'b0, 2'd0);
        Req_Valid = 4'b0001;
        exp_q.push_back(0);
        grant_hs(4'b0000, 1'b0, 2'd0);
        Req_Valid = 4'b0010;
        exp_q.push_back(1);
        wait_grant();
        chk("pre_rst_full", Outstanding_Full, 4'b0100);
        ARESET = 1'b1; Req_Valid = 4'b0000;
        tick();
        chk("midrst_valid", Grant_Valid, 0);
        chk("midrst_onehot", Grant_Onehot, 0);
        chk("midrst_sel", Selected_Master, 0);
        chk("midrst_full", Outstanding_Full, 0);
        chk("midrst_err", Count_Error, 0);
        chk("midrst_chreq", Channel_Request, 0);
        ARESET = 1'b0; Req_Valid = 4'b0001;
        exp_q.push_back(0);
        tick();
        chk("post_rst_latency", Grant_Valid, 1);
        grant_hs(4'b0000, 1'b0, 2'd0);
        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
